// File: rtl/fft_frame_writer.sv
// Captures one 256-point FFT output frame into the re/im frame RAMs through port A.
// Holds frame_ready until acknowledged; index-0 frame starts arriving meanwhile are dropped and counted.
module fft_frame_writer #(
    parameter int DW  = 23,
    parameter int AW  = 8,
    parameter int FCW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           fft_dv,
    input  logic [AW-1:0]  fft_index,
    input  logic [DW-1:0]  fft_re,
    input  logic [DW-1:0]  fft_im,
    input  logic           frame_ack,
    output logic           wea,
    output logic [AW-1:0]  addra,
    output logic [DW-1:0]  dina_re,
    output logic [DW-1:0]  dina_im,
    output logic           frame_ready,
    output logic [FCW-1:0] frame_cnt,
    output logic [7:0]     drop_cnt,
    output logic           seq_err
);

    // state | meaning
    // IDLE  | waiting for an index-0 sample to start a frame
    // WRITE | capturing, next expected index in exp_idx
    // HOLD  | frame complete and stored, waiting for frame_ack
    typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

    localparam logic [AW-1:0] LAST_IDX = '1;

    state_t         state, state_nx;
    logic [AW-1:0]  exp_idx, exp_idx_nx;
    logic           pend, pend_nx;
    logic           take;
    logic           wea_nx;
    logic [AW-1:0]  addra_nx;
    logic [DW-1:0]  dina_re_nx, dina_im_nx;
    logic           frame_ready_nx;
    logic [FCW-1:0] frame_cnt_nx;
    logic [7:0]     drop_cnt_nx;
    logic           seq_err_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            exp_idx     <= '0;
            pend        <= 1'b0;
            wea         <= 1'b0;
            addra       <= '0;
            dina_re     <= '0;
            dina_im     <= '0;
            frame_ready <= 1'b0;
            frame_cnt   <= '0;
            drop_cnt    <= '0;
            seq_err     <= 1'b0;
        end else begin
            state       <= state_nx;
            exp_idx     <= exp_idx_nx;
            pend        <= pend_nx;
            wea         <= wea_nx;
            addra       <= addra_nx;
            dina_re     <= dina_re_nx;
            dina_im     <= dina_im_nx;
            frame_ready <= frame_ready_nx;
            frame_cnt   <= frame_cnt_nx;
            drop_cnt    <= drop_cnt_nx;
            seq_err     <= seq_err_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        exp_idx_nx     = exp_idx;
        pend_nx        = 1'b0;
        take           = 1'b0;
        wea_nx         = 1'b0;
        addra_nx       = addra;
        dina_re_nx     = dina_re;
        dina_im_nx     = dina_im;
        frame_ready_nx = frame_ready;
        frame_cnt_nx   = frame_cnt;
        drop_cnt_nx    = drop_cnt;
        seq_err_nx     = 1'b0;

        // pend delays frame_ready one cycle so it rises after the last write is visible
        if (pend) begin
            frame_ready_nx = 1'b1;
            frame_cnt_nx   = frame_cnt + FCW'(1);
        end

        case (state)
            IDLE: begin
                if (fft_dv && fft_index == '0) begin
                    take       = 1'b1;
                    exp_idx_nx = AW'(1);
                    state_nx   = WRITE;
                end
            end
            WRITE: begin
                if (fft_dv) begin
                    if (fft_index == exp_idx) begin
                        take       = 1'b1;
                        exp_idx_nx = exp_idx + AW'(1);
                        if (exp_idx == LAST_IDX) begin
                            state_nx = HOLD;
                            pend_nx  = 1'b1;
                        end
                    end else begin
                        seq_err_nx = 1'b1;
                        if (fft_index == '0) begin
                            take       = 1'b1;
                            exp_idx_nx = AW'(1);
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
            end
            HOLD: begin
                if (fft_dv && fft_index == '0 && drop_cnt != 8'hFF)
                    drop_cnt_nx = drop_cnt + 8'd1;
                // ack only counts once the reader could have seen frame_ready
                if (frame_ready && frame_ack) begin
                    frame_ready_nx = 1'b0;
                    state_nx       = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (take) begin
            wea_nx     = 1'b1;
            addra_nx   = fft_index;
            dina_re_nx = fft_re;
            dina_im_nx = fft_im;
        end
    end

endmodule

// File: tb/tb_fft_frame_writer.sv
// Directed and randomized checks of fft_frame_writer against a frame-level reference model.
module tb_fft_frame_writer;
    localparam int DW  = 23;
    localparam int AW  = 8;
    localparam int FCW = 16;
    localparam int N   = 256;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           fft_dv = 1'b0;
    logic [AW-1:0]  fft_index = '0;
    logic [DW-1:0]  fft_re = '0;
    logic [DW-1:0]  fft_im = '0;
    logic           frame_ack = 1'b0;
    logic           wea;
    logic [AW-1:0]  addra;
    logic [DW-1:0]  dina_re;
    logic [DW-1:0]  dina_im;
    logic           frame_ready;
    logic [FCW-1:0] frame_cnt;
    logic [7:0]     drop_cnt;
    logic           seq_err;

    fft_frame_writer #(.DW(DW), .AW(AW), .FCW(FCW)) dut (
        .clk(clk), .rst(rst), .fft_dv(fft_dv), .fft_index(fft_index),
        .fft_re(fft_re), .fft_im(fft_im), .frame_ack(frame_ack),
        .wea(wea), .addra(addra), .dina_re(dina_re), .dina_im(dina_im),
        .frame_ready(frame_ready), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
        .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int wea_seen = 0;

    // reference model: next_bin < 0 means not capturing
    logic           m_wea = 1'b0, m_seq = 1'b0, m_ready = 1'b0;
    logic [AW-1:0]  m_addr = '0;
    logic [DW-1:0]  m_re = '0, m_im = '0;
    logic [FCW-1:0] m_fcnt = '0;
    int             m_drop = 0;
    int             next_bin = -1;
    bit             stored = 1'b0;
    bit             announce = 1'b0;

    function automatic logic [DW-1:0] rd();
        return DW'($urandom());
    endfunction

    task automatic model_write();
        m_wea  = 1'b1;
        m_addr = fft_index;
        m_re   = fft_re;
        m_im   = fft_im;
    endtask

    task automatic model_step();
        bit was_ready;
        if (rst) begin
            m_wea = 0; m_seq = 0; m_ready = 0; m_addr = '0; m_re = '0; m_im = '0;
            m_fcnt = '0; m_drop = 0; next_bin = -1; stored = 0; announce = 0;
        end else begin
            was_ready = m_ready;
            m_wea = 0;
            m_seq = 0;
            if (announce) begin
                m_ready  = 1;
                m_fcnt   = m_fcnt + 1'b1;
                announce = 0;
            end
            if (stored) begin
                if (fft_dv && int'(fft_index) == 0 && m_drop < 255) m_drop++;
                if (was_ready && frame_ack) begin
                    m_ready = 0;
                    stored  = 0;
                end
            end else if (fft_dv) begin
                if (next_bin < 0) begin
                    if (int'(fft_index) == 0) begin model_write(); next_bin = 1; end
                end else if (int'(fft_index) == next_bin) begin
                    model_write();
                    if (next_bin == N-1) begin
                        stored = 1; announce = 1; next_bin = -1;
                    end else next_bin++;
                end else begin
                    m_seq = 1;
                    if (int'(fft_index) == 0) begin model_write(); next_bin = 1; end
                    else next_bin = -1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("wea", 32'(wea), 32'(m_wea));
        chk("addra", 32'(addra), 32'(m_addr));
        chk("dina_re", 32'(dina_re), 32'(m_re));
        chk("dina_im", 32'(dina_im), 32'(m_im));
        chk("frame_ready", 32'(frame_ready), 32'(m_ready));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("seq_err", 32'(seq_err), 32'(m_seq));
    endtask

    task automatic cyc(input bit dv, input int idx, input logic [DW-1:0] re,
                       input logic [DW-1:0] im, input bit ack, input bit r);
        rst       = r;
        fft_dv    = dv;
        fft_index = AW'(idx);
        fft_re    = re;
        fft_im    = im;
        frame_ack = ack;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (wea) wea_seen++;
    endtask

    task automatic rnd(input bit dv, input int idx, input bit ack);
        cyc(dv, idx, rd(), rd(), ack, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) rnd(1'b0, 0, 1'b0);
    endtask

    task automatic run(input int first, input int last, input int gap);
        for (int i = first; i <= last; i++) begin
            rnd(1'b1, i, 1'b0);
            for (int g = 0; g < gap; g++) rnd(1'b0, 0, 1'b0);
        end
    endtask

    task automatic ack_pulse();
        rnd(1'b0, 0, 1'b1);
        rnd(1'b0, 0, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] v;
        int p;
        bit dv;
        int idx;

        // reset
        cyc(0, 0, '0, '0, 0, 1);
        cyc(0, 0, '0, '0, 0, 1);
        chk("reset_frame_ready", 32'(frame_ready), 32'd0);

        // contiguous frame, re=k, im=~k
        wea_seen = 0;
        for (int k = 0; k < N; k++) begin
            v = DW'(k);
            cyc(1, k, v, ~v, 0, 0);
        end
        idle(3);
        chk("contig_wea_count", 32'(wea_seen), 32'd256);
        chk("contig_frame_cnt", 32'(frame_cnt), 32'd1);
        ack_pulse();

        // gappy frame
        wea_seen = 0;
        run(0, N-1, 2);
        idle(2);
        chk("gappy_wea_count", 32'(wea_seen), 32'd256);
        ack_pulse();

        // mid-stream join, then sequence errors
        wea_seen = 0;
        run(100, 130, 0);
        chk("join_no_writes", 32'(wea_seen), 32'd0);
        run(0, 40, 0);
        rnd(1, 50, 0);
        run(51, 60, 0);
        run(0, 40, 0);
        run(0, N-1, 0);
        idle(3);
        chk("restart_frame_cnt", 32'(frame_cnt), 32'd3);

        // hold and drop: three frames while unacknowledged
        wea_seen = 0;
        for (int f = 0; f < 3; f++) run(0, N-1, 0);
        chk("hold_no_writes", 32'(wea_seen), 32'd0);
        chk("hold_drop_cnt", 32'(drop_cnt), 32'd3);
        ack_pulse();
        run(0, N-1, 0);
        idle(3);

        // ack coincides with frame start: frame lost
        wea_seen = 0;
        rnd(1, 0, 1);
        run(1, N-1, 0);
        chk("coincide_no_writes", 32'(wea_seen), 32'd0);
        run(0, N-1, 1);
        idle(3);
        ack_pulse();

        // reset mid-frame
        run(0, 120, 0);
        cyc(0, 0, rd(), rd(), 0, 1);
        chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        wea_seen = 0;
        run(121, 200, 0);
        chk("midrst_ignored", 32'(wea_seen), 32'd0);
        run(0, N-1, 0);
        idle(3);
        ack_pulse();

        // randomized streaming with glitches, acks and rare resets
        p = 0;
        for (int c = 0; c < 6000; c++) begin
            dv  = ($urandom_range(0, 3) != 0);
            idx = ($urandom_range(0, 60) == 0) ? int'($urandom_range(0, N-1)) : p;
            if (dv && idx == p) p = (p + 1) % N;
            cyc(dv, idx, rd(), rd(), ($urandom_range(0, 40) == 0), ($urandom_range(0, 1999) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
